arrival_predictor: RTL and testbench
====================================

// Module: arrival_predictor
// PURPOSE
//  Measures time between successive track-sensor pulses in units of a timebase tick.
//  Predicts the train's arrival time at the next point as interval * RATIO, saturated to OUT_W.
//  Prediction uses either the last interval or the average of the last DEPTH intervals.
//  Runs a countdown to the predicted arrival and flags it. Sits between the sensor debouncers and the controller FSM.
// PARAMETERS
//  IN_W   15  interval counter width in ticks; saturates at 2^IN_W-1
//  OUT_W  19  prediction / countdown width in ticks
//  DEPTH  4   interval history depth; power of two, >=2
//  RATIO  16  distance ratio multiplier, unsigned, 1..31 (5 bits)
// PORTS
//  clk           in   1      system clock, rising edge
//  rst_n         in   1      asynchronous active-low reset
//  clr           in   1      synchronous clear; same effect as reset, takes one cycle
//  tick          in   1      timebase enable, one-cycle pulse
//  sensor_pulse  in   1      debounced sensor event, one-cycle pulse
//  mode          in   1      0 = last interval; 1 = DEPTH-average
//  time_out      out  OUT_W  predicted arrival ticks; held until next prediction
//  pred_valid    out  1      one-cycle strobe when time_out updates
//  remaining     out  OUT_W  ticks left to predicted arrival
//  arrival_due   out  1      one-cycle strobe when remaining goes 1 -> 0
//  stale         out  1      interval counter saturated (train lost)
//  hist_full     out  1      DEPTH valid intervals held
// BEHAVIOUR
//  Reset / clr: all outputs 0; counter 0; history, sum and fill count 0; state IDLE.
//  States:
//   IDLE: the first pulse moves to ARMED and zeroes the counter. No prediction is made.
//   ARMED: the counter increments on tick and saturates at 2^IN_W-1.
//    stale=1 while the counter is saturated.
//   ARMED, pulse with counter unsaturated:
//    interval = counter value before this cycle; a tick in the same cycle is not counted.
//    Counter resets to 0.
//   ARMED, pulse with counter saturated:
//    History, sum and fill count clear; counter resets to 0; stale drops.
//    State stays ARMED. No prediction is made.
//  Pipeline: pulse sampled in cycle N.
//   N+1: interval written at wr_ptr (mod DEPTH); sum += interval - evicted entry.
//        fill count increments, saturating at DEPTH.
//   N+2: pred_valid=1; time_out loaded; remaining loaded with time_out.
//  Sum width is IN_W+log2(DEPTH); avg = sum >> log2(DEPTH), truncating.
//  Base value selection:
//   mode=0 -> last interval.
//   mode=1 and hist_full -> avg.
//   mode=1 and not full -> last interval.
//  time_out = min(base * RATIO, 2^OUT_W-1). Product width is IN_W+5.
//  Countdown: on tick and remaining>0, remaining decrements.
//   arrival_due strobes in the cycle remaining becomes 0. Remaining 0 stays 0; no wrap.
//  A pred_valid load overrides a same-cycle tick decrement. A new pulse mid-countdown reloads at N+2.
//  Pulses arriving at N+1 are handled in order: one prediction per pulse, no drops.
//  mode is sampled at N+1.
// TESTING
//  T1 mode=0, pulses 100 ticks apart: 1st pulse -> no pred_valid.
//     2nd pulse -> pred_valid at N+2, time_out=1600, remaining=1600.
//  T2 mode=1, intervals 100,200,300,400: time_out=1600,3200,4800, then 4000 (avg 250).
//     hist_full rises with the 4th interval. A 5th interval of 500 -> time_out=5600.
//  T3 countdown: after time_out=1600, 1600 ticks -> arrival_due one cycle, remaining=0.
//     Further ticks -> remaining stays 0, no further strobe.
//  T4 no pulse for 32767 ticks -> stale=1. Next pulse -> no pred_valid, hist_full=0, stale=0.
//     Pulse 50 ticks later -> time_out=800.
//  T5 RATIO=20, mode=0, interval 32766 -> time_out=524287 (saturated).
//  T6 tick and pulse in same cycle at count 99 -> interval 99.
//     rst_n low mid-countdown -> all outputs 0 immediately, IDLE.

Source files
------------

// File: rtl/arrival_predictor.sv
// Interval timer between track-sensor pulses with arrival-time prediction
// (last interval or history average, scaled by RATIO) and an arrival countdown.
module arrival_predictor #(
    parameter int IN_W  = 15,
    parameter int OUT_W = 19,
    parameter int DEPTH = 4,
    parameter int RATIO = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             tick,
    input  logic             sensor_pulse,
    input  logic             mode,
    output logic [OUT_W-1:0] time_out,
    output logic             pred_valid,
    output logic [OUT_W-1:0] remaining,
    output logic             arrival_due,
    output logic             stale,
    output logic             hist_full
);
    // state | meaning
    // IDLE  | no reference pulse seen yet; counter held at 0
    // ARMED | counting ticks since the last pulse

    localparam int LG     = $clog2(DEPTH);
    localparam int SUM_W  = IN_W + LG;
    localparam int PROD_W = IN_W + 5;
    localparam logic [IN_W-1:0]  CNT_MAX = '1;
    localparam logic [OUT_W-1:0] OUT_MAX = '1;
    localparam logic [LG:0]      FULL    = (LG+1)'(DEPTH);

    typedef enum logic {IDLE, ARMED} state_t;

    state_t            state, state_next;
    logic [IN_W-1:0]   cnt, cnt_next;
    logic              cap, lost;

    logic              s1_valid;
    logic [IN_W-1:0]   s1_iv;

    logic [IN_W-1:0]   hist [DEPTH];
    logic [LG-1:0]     wr_ptr;
    logic [LG:0]       fill, fill_new;
    logic [SUM_W-1:0]  sum, sum_new;
    logic [IN_W-1:0]   evicted, base;
    logic [PROD_W-1:0] prod;
    logic [OUT_W-1:0]  pred;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (clr) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // A pulse consumes the cycle: a coincident tick is not counted.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        cap        = 1'b0;
        lost       = 1'b0;
        case (state)
            IDLE: begin
                if (sensor_pulse) begin
                    state_next = ARMED;
                    cnt_next   = '0;
                end
            end
            ARMED: begin
                if (sensor_pulse) begin
                    cnt_next = '0;
                    if (cnt == CNT_MAX) lost = 1'b1;
                    else                cap  = 1'b1;
                end else if (tick && cnt != CNT_MAX) begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign stale     = (state == ARMED) && (cnt == CNT_MAX);
    assign hist_full = (fill == FULL);

    // Prediction datapath works on the history as it will be after this write.
    always_comb begin
        evicted  = hist[wr_ptr];
        sum_new  = sum + SUM_W'(s1_iv) - SUM_W'(evicted);
        fill_new = (fill == FULL) ? fill : fill + 1'b1;
        base     = (mode && fill_new == FULL) ? IN_W'(sum_new >> LG) : s1_iv;
        prod     = PROD_W'(base) * PROD_W'(RATIO);
        pred     = ((prod >> OUT_W) != '0) ? OUT_MAX : OUT_W'(prod);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_iv    <= '0;
        end else if (clr) begin
            s1_valid <= 1'b0;
            s1_iv    <= '0;
        end else begin
            s1_valid <= cap;
            if (cap) s1_iv <= cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
            wr_ptr <= '0;
            fill   <= '0;
            sum    <= '0;
        end else if (clr || lost) begin
            for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
            wr_ptr <= '0;
            fill   <= '0;
            sum    <= '0;
        end else if (s1_valid) begin
            hist[wr_ptr] <= s1_iv;
            wr_ptr       <= wr_ptr + 1'b1;
            fill         <= fill_new;
            sum          <= sum_new;
        end
    end

    // A fresh prediction takes priority over a same-cycle countdown tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            time_out    <= '0;
            pred_valid  <= 1'b0;
            remaining   <= '0;
            arrival_due <= 1'b0;
        end else if (clr) begin
            time_out    <= '0;
            pred_valid  <= 1'b0;
            remaining   <= '0;
            arrival_due <= 1'b0;
        end else begin
            pred_valid <= s1_valid;
            if (s1_valid) begin
                time_out    <= pred;
                remaining   <= pred;
                arrival_due <= 1'b0;
            end else if (tick && remaining != '0) begin
                remaining   <= remaining - 1'b1;
                arrival_due <= (remaining == OUT_W'(1));
            end else begin
                arrival_due <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arrival_predictor.sv
// Directed plus randomized bench for arrival_predictor against a queue-based
// model of interval history and prediction arithmetic.
module tb_arrival_predictor;
    localparam int MAXC = 32767;
    localparam int MAXO = 524287;

    logic        clk, rst_n, clr, tick, sensor_pulse, mode;
    logic [18:0] time_out, remaining, time_out_s, remaining_s;
    logic        pred_valid, arrival_due, stale, hist_full;
    logic        pred_valid_s, arrival_due_s, stale_s, hist_full_s;

    int vectors = 0;
    int miscompares = 0;

    bit armed = 0;
    int cnt_m = 0;
    int q[$];
    int last_to = 0;
    int last_ts = 0;

    arrival_predictor #(.IN_W(15), .OUT_W(19), .DEPTH(4), .RATIO(16)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .tick(tick),
        .sensor_pulse(sensor_pulse), .mode(mode),
        .time_out(time_out), .pred_valid(pred_valid), .remaining(remaining),
        .arrival_due(arrival_due), .stale(stale), .hist_full(hist_full));

    arrival_predictor #(.IN_W(15), .OUT_W(19), .DEPTH(4), .RATIO(20)) dut_sat (
        .clk(clk), .rst_n(rst_n), .clr(clr), .tick(tick),
        .sensor_pulse(sensor_pulse), .mode(mode),
        .time_out(time_out_s), .pred_valid(pred_valid_s), .remaining(remaining_s),
        .arrival_due(arrival_due_s), .stale(stale_s), .hist_full(hist_full_s));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat_pred(input int base, input int ratio);
        int p;
        p = base * ratio;
        return (p > MAXO) ? MAXO : p;
    endfunction

    task automatic model_reset();
        armed = 0; cnt_m = 0; q.delete(); last_to = 0; last_ts = 0;
    endtask

    task automatic cyc(input bit t, input bit p);
        @(negedge clk);
        tick = t;
        sensor_pulse = p;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b0);
            if (armed && cnt_m < MAXC) cnt_m++;
        end
    endtask

    task automatic model_pulse(output bit pv, output int t16, output int t20, output bit hf);
        int base, s;
        pv = 0;
        if (!armed) begin
            armed = 1; cnt_m = 0;
        end else if (cnt_m == MAXC) begin
            q.delete(); cnt_m = 0;
        end else begin
            q.push_back(cnt_m);
            if (q.size() > 4) void'(q.pop_front());
            cnt_m = 0;
            if (mode && q.size() == 4) begin
                s = 0;
                foreach (q[i]) s += q[i];
                base = s / 4;
            end else begin
                base = q[$];
            end
            pv = 1;
            last_to = sat_pred(base, 16);
            last_ts = sat_pred(base, 20);
        end
        t16 = last_to;
        t20 = last_ts;
        hf  = (q.size() == 4);
    endtask

    task automatic check_pred(input string tag, input bit pv, input int t16, input int t20, input bit hf);
        chk({tag, ".pred_valid"}, pred_valid, pv);
        chk({tag, ".time_out"}, time_out, t16);
        chk({tag, ".time_out_r20"}, time_out_s, t20);
        chk({tag, ".hist_full"}, hist_full, hf);
        chk({tag, ".stale"}, stale, 0);
        if (pv) chk({tag, ".remaining"}, remaining, t16);
    endtask

    task automatic pulse(input string tag, input bit tick_same);
        bit pv, hf;
        int t16, t20;
        cyc(tick_same, 1'b1);
        model_pulse(pv, t16, t20, hf);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        check_pred(tag, pv, t16, t20, hf);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".time_out"}, time_out, 0);
        chk({tag, ".pred_valid"}, pred_valid, 0);
        chk({tag, ".remaining"}, remaining, 0);
        chk({tag, ".arrival_due"}, arrival_due, 0);
        chk({tag, ".stale"}, stale, 0);
        chk({tag, ".hist_full"}, hist_full, 0);
    endtask

    initial begin
        bit pva, hfa, pvb, hfb;
        int a16, a20, b16, b20;
        rst_n = 0; clr = 0; tick = 0; sensor_pulse = 0; mode = 0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1;

        // T1: first pulse gives nothing, 100-tick interval gives 1600
        mode = 0;
        pulse("t1_first", 0);
        ticks(100);
        pulse("t1_second", 0);
        chk("t1_value", time_out, 1600);

        // T3: countdown to arrival
        ticks(1599);
        cyc(0, 0);
        chk("t3_rem1", remaining, 1);
        chk("t3_due_early", arrival_due, 0);
        ticks(1);
        cyc(0, 0);
        chk("t3_rem0", remaining, 0);
        chk("t3_due", arrival_due, 1);
        ticks(5);
        cyc(0, 0);
        chk("t3_hold0", remaining, 0);
        chk("t3_no_restrobe", arrival_due, 0);

        cyc(0, 0); clr = 1;
        cyc(0, 0); clr = 0;
        model_reset();
        check_zero("clr");

        // T2: averaging mode
        mode = 1;
        pulse("t2_first", 0);
        for (int i = 1; i <= 5; i++) begin
            ticks(100 * i);
            pulse($sformatf("t2_iv%0d", i), 0);
        end
        chk("t2_last", time_out, 5600);

        // T6: tick coincident with pulse is not counted
        mode = 0;
        ticks(99);
        pulse("t6_same_tick", 1);
        chk("t6_value", time_out, 1584);

        repeat (12) begin
            mode = 1'($urandom_range(0, 1));
            ticks($urandom_range(0, 400));
            pulse("rand", 1'($urandom_range(0, 1)));
        end

        // back-to-back pulses: both predicted, in order
        mode = 1;
        ticks(37);
        cyc(0, 1); model_pulse(pva, a16, a20, hfa);
        cyc(0, 1); model_pulse(pvb, b16, b20, hfb);
        cyc(0, 0);
        check_pred("b2b_a", pva, a16, a20, hfa);
        cyc(0, 0);
        check_pred("b2b_b", pvb, b16, b20, hfb);

        // T5: largest unsaturated interval, product saturation at RATIO=20
        mode = 0;
        ticks(32766);
        cyc(0, 0);
        chk("t5_not_stale", stale, 0);
        pulse("t5", 0);
        chk("t5_sat", time_out_s, MAXO);

        // T4: train lost
        ticks(32767);
        cyc(0, 0);
        chk("t4_stale", stale, 1);
        pulse("t4_recover", 0);
        ticks(50);
        pulse("t4_after", 0);
        chk("t4_value", time_out, 800);

        // asynchronous reset mid-countdown
        ticks(10);
        #2 rst_n = 0;
        #1 check_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1;
        pulse("post_rst_first", 0);
        ticks(30);
        pulse("post_rst_second", 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
